// File: rtl/switch_pkg.sv
// Shared switch definitions: default port count and the VOQ picker state type.
package switch_pkg;

  localparam int NUM_PORTS_DEF = 4;

  typedef enum logic {
    PICK_IDLE  = 1'b0,
    PICK_OFFER = 1'b1
  } picker_state_e;

endpackage

// File: rtl/rr_find_first.sv
// Rotating-priority first-set finder: starting at start_i and wrapping modulo N,
// report whether any request bit is set and the index of the first one.
module rr_find_first #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] index_o
);

  logic [N-1:0] rot;
  logic [W:0]   sum;

  // Rotate so bit 0 is the start position, then take the lowest set offset
  // and map it back to an absolute index with an exact modulo-N wrap.
  always_comb begin
    rot     = N'({req_i, req_i} >> start_i);
    found_o = |rot;
    sum     = '0;
    index_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, start_i} + (W + 1)'(k);
        if (sum >= (W + 1)'(N)) begin
          sum = sum - (W + 1)'(N);
        end
        index_o = sum[W-1:0];
      end
    end
  end

endmodule

// File: rtl/voq_rr_picker.sv
// VOQ round-robin picker: on a pick request, offers the first non-empty,
// not-yet-picked VOQ at or after the rotating pointer, holds the offer until
// the downstream accepts or rejects, and advances the pointer past accepted
// winners only.
module voq_rr_picker
  import switch_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pick_req,
  input  logic [NUM_PORTS-1:0] voq_empty,
  input  logic [NUM_PORTS-1:0] voq_picked,
  input  logic                 pick_accept,
  input  logic                 pick_reject,
  output logic                 pick_valid,
  output logic [PORT_W-1:0]    voq_to_pick,
  output logic                 no_available_voq,
  output logic [PORT_W-1:0]    rr_ptr
);

  picker_state_e        state_q;
  logic                 valid_q;
  logic                 noav_q;
  logic [PORT_W-1:0]    voq_q;
  logic [PORT_W-1:0]    ptr_q;
  logic [PORT_W-1:0]    ptr_d;
  logic [NUM_PORTS-1:0] eligible;
  logic                 found;
  logic [PORT_W-1:0]    winner;

  assign eligible = ~voq_empty & ~voq_picked;

  rr_find_first #(
    .N(NUM_PORTS),
    .W(PORT_W)
  ) u_find (
    .req_i   (eligible),
    .start_i (ptr_q),
    .found_o (found),
    .index_o (winner)
  );

  // Pointer to use after an accept: one past the held winner, wrapping exactly.
  always_comb begin
    ptr_d = (voq_q == PORT_W'(NUM_PORTS - 1)) ? '0 : voq_q + 1'b1;
  end

  // Picker FSM with all outputs registered; the offer is frozen while in OFFER.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PICK_IDLE;
      valid_q <= 1'b0;
      noav_q  <= 1'b0;
      voq_q   <= '0;
      ptr_q   <= '0;
    end else begin
      noav_q <= 1'b0;
      case (state_q)
        PICK_IDLE: begin
          if (pick_req) begin
            if (found) begin
              state_q <= PICK_OFFER;
              valid_q <= 1'b1;
              voq_q   <= winner;
            end else begin
              noav_q  <= 1'b1;
            end
          end
        end
        PICK_OFFER: begin
          if (pick_accept) begin
            state_q <= PICK_IDLE;
            valid_q <= 1'b0;
            ptr_q   <= ptr_d;
          end else if (pick_reject) begin
            state_q <= PICK_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= PICK_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pick_valid       = valid_q;
  assign voq_to_pick      = voq_q;
  assign no_available_voq = noav_q;
  assign rr_ptr           = ptr_q;

endmodule
